// File: rtl/div_unit_pkg.sv
// Shared types for the iterative RV32M divider: op encodings and FSM states.
package div_unit_pkg;

  typedef enum logic [1:0] {
    DivOpDiv  = 2'b00,
    DivOpDivu = 2'b01,
    DivOpRem  = 2'b10,
    DivOpRemu = 2'b11
  } div_op_e;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StCalc = 2'b01,
    StFix  = 2'b10,
    StDone = 2'b11
  } div_state_e;

  function automatic logic op_is_signed(div_op_e op);
    return (op == DivOpDiv) || (op == DivOpRem);
  endfunction

  function automatic logic op_is_rem(div_op_e op);
    return (op == DivOpRem) || (op == DivOpRemu);
  endfunction

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring division iteration, purely combinational.
module div_step #(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] rem_i,
  input  logic [XLEN-1:0] quot_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic [XLEN-1:0] rem_o,
  output logic [XLEN-1:0] quot_o
);

  logic [XLEN:0] rem_sh;
  logic [XLEN:0] diff;
  logic          no_borrow;

  // Shifted remainder can exceed XLEN bits when the divisor has its MSB set.
  always_comb begin
    rem_sh    = {rem_i, quot_i[XLEN-1]};
    no_borrow = rem_sh >= {1'b0, divisor_i};
    diff      = rem_sh - {1'b0, divisor_i};
    rem_o     = no_borrow ? diff[XLEN-1:0] : rem_sh[XLEN-1:0];
    quot_o    = {quot_i[XLEN-2:0], no_borrow};
  end

endmodule

// File: rtl/div_unit.sv
// Iterative RV32M divider (DIV/DIVU/REM/REMU) with pipeline stall and flush handling.
// Define DIV_SPECIAL_BYPASS_EN to resolve divide-by-zero and signed overflow in one cycle.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_i,
  input  logic [1:0]      op_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  input  logic [4:0]      rd_addr_i,
  input  logic            flush_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o,
  output logic [4:0]      rd_addr_o
);

  localparam int unsigned CntW = $clog2(XLEN) + 1;
  localparam logic [XLEN-1:0] MinNeg = {1'b1, {(XLEN-1){1'b0}}};

  div_state_e      state_q, state_d;
  div_op_e         op_q, op_d;
  logic [4:0]      rd_q, rd_d, rd_out_q, rd_out_d;
  logic [XLEN-1:0] rem_q, rem_d, quot_q, quot_d, divisor_q, divisor_d;
  logic [XLEN-1:0] rs1_q, rs1_d, result_q, result_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            q_neg_q, q_neg_d, r_neg_q, r_neg_d;
  logic            div0_q, div0_d, ovf_q, ovf_d;

  div_op_e         op_in;
  logic            in_signed, in_div0, in_ovf;
  logic [XLEN-1:0] rs1_abs, rs2_abs, step_rem, step_quot, q_fix, r_fix, fix_res;

  function automatic logic [XLEN-1:0] special_result(div_op_e op, logic [XLEN-1:0] dividend,
                                                     logic div0);
    if (div0) return op_is_rem(op) ? dividend : '1;
    return op_is_rem(op) ? '0 : MinNeg;
  endfunction

  assign op_in     = div_op_e'(op_i);
  assign in_signed = op_is_signed(op_in);
  assign in_div0   = (rs2_i == '0);
  assign in_ovf    = in_signed && (rs1_i == MinNeg) && (rs2_i == '1);
  assign rs1_abs   = (in_signed && rs1_i[XLEN-1]) ? -rs1_i : rs1_i;
  assign rs2_abs   = (in_signed && rs2_i[XLEN-1]) ? -rs2_i : rs2_i;

  div_step #(
    .XLEN(XLEN)
  ) u_div_step (
    .rem_i    (rem_q),
    .quot_i   (quot_q),
    .divisor_i(divisor_q),
    .rem_o    (step_rem),
    .quot_o   (step_quot)
  );

  always_comb begin
    q_fix   = q_neg_q ? -quot_q : quot_q;
    r_fix   = r_neg_q ? -rem_q : rem_q;
    fix_res = (div0_q || ovf_q) ? special_result(op_q, rs1_q, div0_q)
                                : (op_is_rem(op_q) ? r_fix : q_fix);
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    rd_d      = rd_q;
    rd_out_d  = rd_out_q;
    rem_d     = rem_q;
    quot_d    = quot_q;
    divisor_d = divisor_q;
    rs1_d     = rs1_q;
    result_d  = result_q;
    cnt_d     = cnt_q;
    q_neg_d   = q_neg_q;
    r_neg_d   = r_neg_q;
    div0_d    = div0_q;
    ovf_d     = ovf_q;

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          op_d      = op_in;
          rd_d      = rd_addr_i;
          rem_d     = '0;
          quot_d    = rs1_abs;
          divisor_d = rs2_abs;
          rs1_d     = rs1_i;
          cnt_d     = CntW'(XLEN);
          q_neg_d   = in_signed && (rs1_i[XLEN-1] ^ rs2_i[XLEN-1]);
          r_neg_d   = in_signed && rs1_i[XLEN-1];
          div0_d    = in_div0;
          ovf_d     = in_ovf;
`ifdef DIV_SPECIAL_BYPASS_EN
          if (in_div0 || in_ovf) begin
            result_d = special_result(op_in, rs1_i, in_div0);
            rd_out_d = rd_addr_i;
            state_d  = StDone;
          end else begin
            state_d = StCalc;
          end
`else
          state_d = StCalc;
`endif
        end
      end
      StCalc: begin
        rem_d  = step_rem;
        quot_d = step_quot;
        cnt_d  = cnt_q - 1'b1;
        if (cnt_q == CntW'(1)) state_d = StFix;
      end
      StFix: begin
        result_d = fix_res;
        rd_out_d = rd_q;
        state_d  = StDone;
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // A flushed op must leave no trace on the visible outputs.
    if (flush_i) begin
      state_d  = StIdle;
      result_d = result_q;
      rd_out_d = rd_out_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      op_q      <= DivOpDiv;
      rd_q      <= '0;
      rd_out_q  <= '0;
      rem_q     <= '0;
      quot_q    <= '0;
      divisor_q <= '0;
      rs1_q     <= '0;
      result_q  <= '0;
      cnt_q     <= '0;
      q_neg_q   <= 1'b0;
      r_neg_q   <= 1'b0;
      div0_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      rd_q      <= rd_d;
      rd_out_q  <= rd_out_d;
      rem_q     <= rem_d;
      quot_q    <= quot_d;
      divisor_q <= divisor_d;
      rs1_q     <= rs1_d;
      result_q  <= result_d;
      cnt_q     <= cnt_d;
      q_neg_q   <= q_neg_d;
      r_neg_q   <= r_neg_d;
      div0_q    <= div0_d;
      ovf_q     <= ovf_d;
    end
  end

  assign busy_o    = !flush_i && ((state_q == StCalc) || (state_q == StFix) ||
                                  ((state_q == StIdle) && start_i));
  assign done_o    = (state_q == StDone) && !flush_i;
  assign result_o  = result_q;
  assign rd_addr_o = rd_out_q;

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: reference model results are queued at issue and
// compared on done_o, along with latency, stall, flush and reset behaviour.
module tb_div_unit;
  import div_unit_pkg::*;

  localparam int unsigned XLEN = 32;
`ifdef DIV_SPECIAL_BYPASS_EN
  localparam int SpecLat = 1;
`else
  localparam int SpecLat = XLEN + 2;
`endif

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start_i = 1'b0;
  logic [1:0]      op_i = 2'b00;
  logic [XLEN-1:0] rs1_i = '0;
  logic [XLEN-1:0] rs2_i = '0;
  logic [4:0]      rd_addr_i = '0;
  logic            flush_i = 1'b0;
  logic            busy_o, done_o;
  logic [XLEN-1:0] result_o;
  logic [4:0]      rd_addr_o;

  div_unit #(.XLEN(XLEN)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_i  (start_i),
    .op_i     (op_i),
    .rs1_i    (rs1_i),
    .rs2_i    (rs2_i),
    .rd_addr_i(rd_addr_i),
    .flush_i  (flush_i),
    .busy_o   (busy_o),
    .done_o   (done_o),
    .result_o (result_o),
    .rd_addr_o(rd_addr_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] res;
    logic [4:0]  rd;
  } exp_t;

  exp_t sb_q[$];
  int unsigned n_checks = 0;
  int unsigned n_pass = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  function automatic logic [31:0] ref_result(logic [1:0] op, logic [31:0] a, logic [31:0] b);
    logic sgn, is_rem;
    sgn    = (op == DivOpDiv) || (op == DivOpRem);
    is_rem = (op == DivOpRem) || (op == DivOpRemu);
    if (b == 32'd0) return is_rem ? a : 32'hFFFF_FFFF;
    if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return is_rem ? 32'd0 : 32'h8000_0000;
    if (sgn) return is_rem ? $signed(a) % $signed(b) : $signed(a) / $signed(b);
    return is_rem ? a % b : a / b;
  endfunction

  function automatic bit is_special(logic [1:0] op, logic [31:0] a, logic [31:0] b);
    bit sgn;
    sgn = (op == DivOpDiv) || (op == DivOpRem);
    return (b == 32'd0) || (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  // Issue one op, hold start_i while stalled, and retire it from the scoreboard on done_o.
  task automatic do_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd);
    int lat;
    bit seen, busy_ok;
    exp_t e;
    lat = is_special(op, a, b) ? SpecLat : XLEN + 2;
    @(negedge clk);
    start_i = 1'b1; op_i = op; rs1_i = a; rs2_i = b; rd_addr_i = rd;
    sb_q.push_back('{res: ref_result(op, a, b), rd: rd});
    #1;
    busy_ok = busy_o;
    seen = 1'b0;
    for (int c = 1; c <= 60 && !seen; c++) begin
      @(posedge clk); #1;
      if (done_o) begin
        seen = 1'b1;
        check_eq({tag, "_lat"}, c, lat);
        check_eq({tag, "_busy_done"}, busy_o, 1'b0);
        if (sb_q.size() == 0) begin
          check_eq({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
          e = sb_q.pop_front();
          check_eq({tag, "_res"}, result_o, e.res);
          check_eq({tag, "_rd"}, rd_addr_o, e.rd);
        end
        start_i = 1'b0;
      end else if (!busy_o) begin
        busy_ok = 1'b0;
      end
    end
    if (!seen) begin
      check_eq({tag, "_timeout"}, 32'd0, 32'd1);
      start_i = 1'b0;
      sb_q.delete();
    end
    check_eq({tag, "_busy_span"}, busy_ok, 1'b1);
    @(posedge clk); #1;
    check_eq({tag, "_one_pulse"}, done_o, 1'b0);
  endtask

  initial begin
    bit done_seen;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_done", done_o, 1'b0);
    check_eq("rst_result", result_o, 32'd0);
    check_eq("rst_rd", rd_addr_o, 5'd0);
    check_eq("rst_busy", busy_o, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    do_op("div100_7", DivOpDiv, 32'd100, 32'd7, 5'd5);
    do_op("rem_m100_7", DivOpRem, -32'sd100, 32'd7, 5'd6);
    do_op("remu_ff_16", DivOpRemu, 32'hFFFF_FFFF, 32'd16, 5'd7);
    do_op("divu_by0", DivOpDivu, 32'd1234, 32'd0, 5'd8);
    do_op("rem_by0", DivOpRem, 32'd1234, 32'd0, 5'd9);
    do_op("div_neg_by0", DivOpDiv, 32'hFFFF_FF00, 32'd0, 5'd10);
    do_op("div_ovf", DivOpDiv, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11);
    do_op("rem_ovf", DivOpRem, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12);
    do_op("divu_bigdiv", DivOpDivu, 32'hFFFF_FFFE, 32'h8000_0001, 5'd13);
    do_op("div_negneg", DivOpDiv, -32'sd77, -32'sd5, 5'd14);
    for (int i = 0; i < 6; i++) begin
      logic [31:0] a, b;
      a = $urandom;
      b = (i < 2) ? 32'($urandom_range(1, 9)) : $urandom;
      do_op($sformatf("rnd%0d", i), 2'($urandom_range(0, 3)), a, b, 5'($urandom_range(1, 31)));
    end

    // Flush in the 10th CALC cycle with start still held by the pipeline.
    @(negedge clk);
    start_i = 1'b1; op_i = DivOpDiv; rs1_i = 32'd1000; rs2_i = 32'd3; rd_addr_i = 5'd20;
    repeat (10) @(posedge clk);
    @(negedge clk);
    flush_i = 1'b1;
    #1;
    check_eq("flush_busy_low", busy_o, 1'b0);
    @(posedge clk); #1;
    check_eq("flush_no_done", done_o, 1'b0);
    @(negedge clk);
    flush_i = 1'b0; start_i = 1'b0;
    #1;
    check_eq("flush_idle_busy", busy_o, 1'b0);
    done_seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done_o || busy_o) done_seen = 1'b1;
    end
    check_eq("flush_quiet", done_seen, 1'b0);
    do_op("divu9_3", DivOpDivu, 32'd9, 32'd3, 5'd21);

    // Reset in the middle of CALC aborts the op.
    @(negedge clk);
    start_i = 1'b1; op_i = DivOpDivu; rs1_i = 32'd500; rs2_i = 32'd4; rd_addr_i = 5'd22;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0; start_i = 1'b0;
    @(posedge clk); #1;
    check_eq("midrst_done", done_o, 1'b0);
    check_eq("midrst_result", result_o, 32'd0);
    check_eq("midrst_rd", rd_addr_o, 5'd0);
    check_eq("midrst_busy", busy_o, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    done_seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done_o) done_seen = 1'b1;
    end
    check_eq("midrst_no_done", done_seen, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
